axi_lite_uart: RTL and testbench

- AXI-lite slave UART peripheral on the CPU's peripheral bus port (m_axi bus signals, 13-bit address window); drives board sout, samples sin.
- Consumes the processor's uncached load/store traffic.
- TX and RX byte FIFOs, programmable per-bit baud divisor, 8N1 framing.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/axi_lite_uart_if.sv | 32 +++
 rtl/uart_fifo.sv | 47 ++++
 rtl/axi_lite_uart.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_uart.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the AXI-lite UART.
package uart_pkg;

  localparam logic [1:0] UART_RX_DATA = 2'd0;
  localparam logic [1:0] UART_TX_DATA = 2'd1;
  localparam logic [1:0] UART_STATUS  = 2'd2;
  localparam logic [1:0] UART_DIVISOR = 2'd3;

  localparam int ST_RX_NOT_EMPTY = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_RX_OVERRUN   = 2;
  localparam int ST_TX_EMPTY     = 3;

  typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // A programmed divisor of 0 behaves as 1 so the bit timers never stall.
  function automatic logic [15:0] eff_divisor(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/axi_lite_uart_if.sv
// AXI-lite bus bundle between the CPU peripheral port and the UART.
interface axi_lite_uart_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/uart_fifo.sv
// 8-bit synchronous FIFO; DEPTH must be a power of two so pointers wrap naturally.
module uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // A pop frees the slot a same-cycle push on a full FIFO lands in.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/axi_lite_uart.sv
// AXI-lite 8N1 UART with TX/RX FIFOs and programmable bit divisor.
// Optional UART_IRQ_EN adds the irq output and the ie field at divisor[17:16].
//   state     | meaning
//   BUS_IDLE  | ready to accept an address (read) or aw/w pair (write)
//   BUS_RESP  | holding rvalid / bvalid until the master takes it
//   TX_IDLE   | line high, waiting for a byte in the TX FIFO
//   TX_START  | driving the start bit
//   TX_DATA   | shifting 8 data bits, LSB first
//   TX_STOP   | driving the stop bit
//   RX_IDLE   | waiting for a falling edge on the synchronised line
//   RX_START  | checking the start bit at mid-bit
//   RX_DATA   | sampling 8 data bits
//   RX_STOP   | sampling the stop bit, then push or discard
module axi_lite_uart
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868,
  parameter int          ADDR_W          = 13
) (
  input  logic            clk,
  input  logic            rst,
  axi_lite_uart_if.slave  bus,
  input  logic            sin,
  output logic            sout
`ifdef UART_IRQ_EN
  ,
  output logic            irq
`endif
);
  logic [ADDR_W-1:0] ar_addr, aw_addr;
  logic [1:0]        ar_sel, aw_sel;
  logic              unused_bits;

  assign ar_addr     = bus.araddr;
  assign aw_addr     = bus.awaddr;
  assign ar_sel      = ar_addr[3:2];
  assign aw_sel      = aw_addr[3:2];
  assign unused_bits = ^{ar_addr, aw_addr, bus.wdata, bus.wstrb};

  logic [15:0] div_q, div_eff, div_load, div_half, half_load;
  logic [1:0]  ie_q;
  logic        overrun_q;

  assign div_eff   = eff_divisor(div_q);
  assign div_load  = div_eff - 16'd1;
  assign div_half  = div_eff >> 1;
  assign half_load = (div_half == 16'd0) ? 16'd0 : div_half - 16'd1;

  logic       tx_push, tx_pop, tx_fifo_full, tx_fifo_empty;
  logic [7:0] tx_pop_data;
  logic       rx_push, rx_pop, rx_fifo_full, rx_fifo_empty, rx_ovf;
  logic [7:0] rx_pop_data, rx_shift, rx_shift_n;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .push_data(bus.wdata[7:0]),
    .pop(tx_pop), .pop_data(tx_pop_data), .full(tx_fifo_full), .empty(tx_fifo_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .push_data(rx_shift_n),
    .pop(rx_pop), .pop_data(rx_pop_data), .full(rx_fifo_full), .empty(rx_fifo_empty)
  );

  tx_state_t tx_state, tx_state_n;
  logic      tx_empty;
  assign tx_empty = tx_fifo_empty && (tx_state == TX_IDLE);

  // ---------------- read channel ----------------
  bus_state_t  rd_state, rd_state_n;
  logic        rd_en_q, ar_fire;
  logic [31:0] rd_val, rdata_q, status_word;

  assign bus.arready = rd_en_q && (rd_state == BUS_IDLE);
  assign ar_fire     = bus.arvalid && bus.arready;
  assign bus.rvalid  = (rd_state == BUS_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = 2'b00;
  assign rx_pop      = ar_fire && (ar_sel == UART_RX_DATA) && !rx_fifo_empty;

  always_comb begin
    status_word                  = '0;
    status_word[ST_RX_NOT_EMPTY] = !rx_fifo_empty;
    status_word[ST_TX_FULL]      = tx_fifo_full;
    status_word[ST_RX_OVERRUN]   = overrun_q;
    status_word[ST_TX_EMPTY]     = tx_empty;
  end

  always_comb begin
    rd_val = '0;
    case (ar_sel)
      UART_RX_DATA: rd_val = rx_fifo_empty ? 32'd0 : {24'd0, rx_pop_data};
      UART_STATUS:  rd_val = status_word;
      UART_DIVISOR: rd_val = {14'd0, ie_q, div_q};
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    rd_state_n = rd_state;
    case (rd_state)
      BUS_IDLE: if (ar_fire)    rd_state_n = BUS_RESP;
      BUS_RESP: if (bus.rready) rd_state_n = BUS_IDLE;
      default:                  rd_state_n = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= BUS_IDLE;
      rd_en_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_state <= rd_state_n;
      rd_en_q  <= 1'b1;
      if (ar_fire) rdata_q <= rd_val;
    end
  end

  // ---------------- write channel ----------------
  bus_state_t wr_state, wr_state_n;
  logic       aw_fire, ovr_clr;

  assign aw_fire     = (wr_state == BUS_IDLE) && bus.awvalid && bus.wvalid;
  assign bus.awready = aw_fire;
  assign bus.wready  = aw_fire;
  assign bus.bvalid  = (wr_state == BUS_RESP);
  assign bus.bresp   = 2'b00;
  assign tx_push     = aw_fire && (aw_sel == UART_TX_DATA) && bus.wstrb[0];
  assign ovr_clr     = aw_fire && (aw_sel == UART_STATUS) && bus.wstrb[0] && bus.wdata[ST_RX_OVERRUN];

  always_comb begin
    wr_state_n = wr_state;
    case (wr_state)
      BUS_IDLE: if (aw_fire)    wr_state_n = BUS_RESP;
      BUS_RESP: if (bus.bready) wr_state_n = BUS_IDLE;
      default:                  wr_state_n = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state  <= BUS_IDLE;
      div_q     <= DEFAULT_DIVISOR;
      overrun_q <= 1'b0;
    end else begin
      wr_state <= wr_state_n;
      if (aw_fire && (aw_sel == UART_DIVISOR)) begin
        if (bus.wstrb[0]) div_q[7:0]  <= bus.wdata[7:0];
        if (bus.wstrb[1]) div_q[15:8] <= bus.wdata[15:8];
      end
      // A new overrun wins over a same-cycle clear.
      if (rx_ovf)       overrun_q <= 1'b1;
      else if (ovr_clr) overrun_q <= 1'b0;
    end
  end

`ifdef UART_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (aw_fire && (aw_sel == UART_DIVISOR) && bus.wstrb[2]) ie_q <= bus.wdata[17:16];
      irq <= (!rx_fifo_empty && ie_q[0]) || (tx_empty && ie_q[1]);
    end
  end
`else
  assign ie_q = 2'b00;
`endif

  // ---------------- transmitter ----------------
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        sout_n;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    sout_n     = sout;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        sout_n = 1'b1;
        if (!tx_fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_pop_data;
          tx_cnt_n   = div_load;
          tx_state_n = TX_START;
          sout_n     = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == 16'd0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = div_load;
          tx_idx_n   = 3'd0;
          sout_n     = tx_shift[0];
        end else tx_cnt_n = tx_cnt - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt == 16'd0) begin
          tx_cnt_n = div_load;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
            sout_n     = 1'b1;
          end else begin
            tx_idx_n   = tx_idx + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            sout_n     = tx_shift[1];
          end
        end else tx_cnt_n = tx_cnt - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt == 16'd0) begin
          // Chain straight into the next start bit when more data waits.
          if (!tx_fifo_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_pop_data;
            tx_cnt_n   = div_load;
            tx_state_n = TX_START;
            sout_n     = 1'b0;
          end else begin
            tx_state_n = TX_IDLE;
            sout_n     = 1'b1;
          end
        end else tx_cnt_n = tx_cnt - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      sout     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      sout     <= sout_n;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic        sin_meta, sin_sync, sin_d;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    rx_ovf     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (sin_d && !sin_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = half_load;
        end
      end
      RX_START: begin
        if (rx_cnt == 16'd0) begin
          if (sin_sync) rx_state_n = RX_IDLE;
          else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = div_load;
            rx_idx_n   = 3'd0;
          end
        end else rx_cnt_n = rx_cnt - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt == 16'd0) begin
          rx_shift_n = {sin_sync, rx_shift[7:1]};
          rx_cnt_n   = div_load;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else rx_cnt_n = rx_cnt - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt == 16'd0) begin
          rx_state_n = RX_IDLE;
          if (sin_sync) begin
            if (rx_fifo_full) rx_ovf  = 1'b1;
            else              rx_push = 1'b1;
          end
        end else rx_cnt_n = rx_cnt - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_meta <= 1'b1;
      sin_sync <= 1'b1;
      sin_d    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      sin_meta <= sin;
      sin_sync <= sin_meta;
      sin_d    <= sin_sync;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end
endmodule

// File: tb/tb_axi_lite_uart.sv
// Directed self-checking bench for axi_lite_uart (default build, 4-cycle bits where possible).
module tb_axi_lite_uart;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b1;
  logic sout;
`ifdef UART_IRQ_EN
  logic irq;
`endif
  int total = 0;
  int bad   = 0;

  axi_lite_uart_if #(.ADDR_W(13)) bus ();

  axi_lite_uart #(.FIFO_DEPTH(16), .DEFAULT_DIVISOR(16'd868), .ADDR_W(13)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sin(sin), .sout(sout)
`ifdef UART_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic axi_read(input logic [12:0] addr, output logic [31:0] data, output int lat);
    int n;
    @(posedge clk); #1;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic axi_write(input logic [12:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(posedge clk); #1;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL write_resp_timeout: bvalid got %b want 1", bus.bvalid); end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input int per);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      sin = fr[i];
      repeat (per) @(posedge clk);
      #1;
    end
    sin = 1'b1;
    repeat (2 * per) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    rst = 1'b1;
    sin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sout, bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000",
                      {sout, bus.rvalid, bus.bvalid, bus.arready, bus.awready, bus.wready});
    end
    total++;
    if ({bus.rdata, bus.rresp, bus.bresp} !== 36'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {bus.rdata, bus.rresp, bus.bresp});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL reset_status: got %h want 00000008", d); end
    total++;
    if (lat !== 1) begin bad++; $display("FAIL read_latency: got %0d want 1", lat); end
    axi_read(13'hC, d, lat);
    total++;
    if (d !== 32'h364) begin bad++; $display("FAIL reset_divisor: got %h want 00000364", d); end
    axi_read(13'h0, d, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_rx_empty: got %h want 0", d); end
  endtask

  // Programs the divisor, queues nb bytes and checks every sampled cycle of the frames.
  task automatic test_tx(input logic [15:0] div, input logic [15:0] bytes, input int nb, input string tag);
    logic [31:0] d;
    int lat;
    int per;
    per = (div == 16'd0) ? 1 : int'(div);
    axi_write(13'hC, {16'd0, div}, 4'b0011);
    fork
      begin
        for (int i = 0; i < nb; i++) axi_write(13'h4, {24'd0, bytes[8*i +: 8]}, 4'b0001);
      end
      begin
        int n;
        int ok;
        logic ex;
        n = 0;
        @(negedge clk);
        while (sout !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        total++;
        if (n >= 400) begin
          bad++; $display("FAIL %s_start: sout got %b want 0", tag, sout);
        end else begin
          for (int p = 0; p < nb * 10; p++) begin
            case (p % 10)
              0:       ex = 1'b0;
              9:       ex = 1'b1;
              default: ex = bytes[8 * (p / 10) + (p % 10) - 1];
            endcase
            ok = 1;
            for (int k = 0; k < per; k++) begin
              if (p != 0 || k != 0) @(negedge clk);
              if (sout !== ex) ok = 0;
            end
            total++;
            if (ok == 0) begin bad++; $display("FAIL %s_bit%0d: sout got %b want %b", tag, p, sout, ex); end
          end
          @(negedge clk);
          total++;
          if (sout !== 1'b1) begin bad++; $display("FAIL %s_idle: sout got %b want 1", tag, sout); end
        end
      end
    join
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL %s_tx_empty: got %h want 00000008", tag, d); end
  endtask

  task automatic test_rx();
    logic [31:0] d;
    int lat;
    axi_write(13'hC, 32'd4, 4'b0011);
    rx_send(8'hA3, 4);
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h9) begin bad++; $display("FAIL rx_status_full: got %h want 00000009", d); end
    axi_read(13'h0, d, lat);
    total++;
    if (d !== 32'hA3) begin bad++; $display("FAIL rx_data: got %h want 000000a3", d); end
    axi_read(13'h0, d, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rx_second_read: got %h want 0", d); end
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL rx_status_empty: got %h want 00000008", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [7:0]  v;
    int lat;
    for (int i = 0; i < 17; i++) begin
      v = 8'(i * 37 + 5);
      rx_send(v, 4);
    end
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'hD) begin bad++; $display("FAIL ovr_status: got %h want 0000000d", d); end
    for (int i = 0; i < 16; i++) begin
      v = 8'(i * 37 + 5);
      axi_read(13'h0, d, lat);
      total++;
      if (d !== {24'd0, v}) begin bad++; $display("FAIL ovr_byte%0d: got %h want %h", i, d, {24'd0, v}); end
    end
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'hC) begin bad++; $display("FAIL ovr_drained: got %h want 0000000c", d); end
    axi_write(13'h8, 32'h4, 4'b0001);
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL ovr_clear: got %h want 00000008", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    int lat;
    int n;
    @(posedge clk); #1;
    bus.awaddr  = 13'hC;
    bus.wdata   = 32'd4;
    bus.wstrb   = 4'b0011;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    bus.wdata = 32'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.bvalid, bus.awready} !== 2'b10) begin
        bad++; $display("FAIL bp_hold%0d: bvalid,awready got %b want 10", i, {bus.bvalid, bus.awready});
      end
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.bvalid, bus.awready} !== 2'b01) begin
      bad++; $display("FAIL bp_release: bvalid,awready got %b want 01", {bus.bvalid, bus.awready});
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(negedge clk);
    total++;
    if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL bp_second_resp: bvalid got %b want 1", bus.bvalid); end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    axi_read(13'hC, d, lat);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL bp_divisor: got %h want 00000005", d); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    int lat;
    axi_write(13'hC, 32'd8, 4'b0011);
    @(posedge clk); #1;
    sin = 1'b0;
    @(posedge clk); #1;
    sin = 1'b1;
    repeat (40) @(posedge clk);
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL glitch_status: got %h want 00000008", d); end
    axi_read(13'h0, d, lat);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL glitch_rx: got %h want 0", d); end
  endtask

  task automatic test_rst_mid_tx();
    logic [31:0] d;
    int lat;
    int n;
    axi_write(13'h4, 32'h00, 4'b0001);
    n = 0;
    @(negedge clk);
    while (sout !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (sout !== 1'b0) begin bad++; $display("FAIL rst_pre: sout got %b want 0", sout); end
    rst = 1'b1;
    #1;
    total++;
    if (sout !== 1'b1) begin bad++; $display("FAIL rst_async: sout got %b want 1", sout); end
    @(negedge clk);
    total++;
    if (sout !== 1'b1) begin bad++; $display("FAIL rst_next: sout got %b want 1", sout); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    axi_read(13'h8, d, lat);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL rst_status: got %h want 00000008", d); end
    axi_read(13'hC, d, lat);
    total++;
    if (d !== 32'h364) begin bad++; $display("FAIL rst_divisor: got %h want 00000364", d); end
  endtask

  initial begin
    test_reset();
    test_tx(16'd4, 16'h0055, 1, "tx55");
    test_tx(16'd0, 16'h0096, 1, "tx_div0");
    test_tx(16'd4, 16'hF00F, 2, "b2b");
    test_rx();
    test_overrun();
    test_backpressure();
    test_glitch();
    test_rst_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
